// File: rtl/tinker_fetch_queue.sv
// Tinker instruction fetch stage: in-order 32-bit fetch requests, a small prefetch
// queue of {pc, insn} entries toward decode, and redirect flush with in-flight drop.
module tinker_fetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [63:0] RESET_PC        = 64'h2000
) (
  input  logic        clock,
  input  logic        rst,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_insn,
  output logic [63:0] out_pc,
  input  logic        out_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   rsp_pc_q, rsp_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [OW-1:0] o_q, o_d;
  logic [OW-1:0] d_q, d_d;

  logic [63:0]   ent_pc_q   [DEPTH];
  logic [31:0]   ent_insn_q [DEPTH];

  logic          req_fire;
  logic          rsp_live;
  logic          push;
  logic          pop;
  logic [31:0]   credit_used;
  logic [PW-1:0] out_idx;
  logic [63:0]   redirect_aligned;

  // Live (non-dropped) requests already own a queue slot, so the queue cannot overflow.
  assign credit_used      = 32'(occ_q) + 32'(o_q - d_q);
  assign redirect_aligned = redirect_pc & ~64'd3;

  assign mem_req_valid = rst && !redirect_valid
                      && (32'(o_q) < MAX_OUTSTANDING)
                      && (credit_used < DEPTH);
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_live      = mem_rsp_valid && (o_q != '0);

  // An empty queue keeps showing the most recently popped slot.
  assign out_idx   = (occ_q == '0) ? head_q - PW'(1) : head_q;
  assign out_valid = (occ_q != '0) && !redirect_valid;
  assign out_insn  = ent_insn_q[out_idx];
  assign out_pc    = ent_pc_q[out_idx];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    o_d        = o_q;
    d_d        = d_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (redirect_valid) begin
      occ_d      = '0;
      tail_d     = head_q;
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      o_d        = o_q - OW'(rsp_live);
      d_d        = o_q - OW'(rsp_live);
    end else begin
      pop  = out_valid && out_ready;
      push = rsp_live && (d_q == '0);
      if (rsp_live && (d_q != '0)) d_d = d_q - OW'(1);
      if (push) begin
        tail_d   = tail_q + PW'(1);
        rsp_pc_d = rsp_pc_q + 64'd4;
      end
      if (pop) head_d = head_q + PW'(1);
      occ_d = occ_q + CW'(push) - CW'(pop);
      o_d   = o_q + OW'(req_fire) - OW'(rsp_live);
      if (req_fire) fetch_pc_d = fetch_pc_q + 64'd4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      o_q        <= '0;
      d_q        <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      o_q        <= o_d;
      d_q        <= d_d;
    end
  end

  // NOTE: entry storage is reset so the head outputs read as zero during and right after reset.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]   <= '0;
        ent_insn_q[i] <= '0;
      end
    end else if (push) begin
      ent_pc_q[tail_q]   <= rsp_pc_q;
      ent_insn_q[tail_q] <= mem_rsp_data;
    end
  end

  // A response with nothing outstanding is a memory-side protocol violation.
  rsp_needs_request: assert property (@(posedge clock) disable iff (!rst)
    mem_rsp_valid |-> (o_q != '0));

endmodule
